main_memory_responder: RTL and testbench
========================================

# main_memory_responder

Backing-store responder on the memory side of the L2 cache. It accepts whole-block read and write requests from the L2 memory interface and models a fixed-latency main memory. Reads return a block on `mem_data_block` with a one-cycle `mem_ready` pulse; writes commit to the array after a fixed latency. It sits between the L2 cache and the top-level memory boundary, and is used as both the simulation memory and the synthesizable on-chip store.

## Interface
- `DATA_WIDTH`, 32: bits per word.
- `ADDR_WIDTH`, 11: word address width; store depth is 2^ADDR_WIDTH words.
- `BLOCK_SIZE`, 32: words per block; `NUM_BLOCKS` = 2^ADDR_WIDTH / BLOCK_SIZE.
- `READ_LATENCY`, 4: cycles from request acceptance to `mem_ready`; must be >= 1.
- `WRITE_LATENCY`, 2: cycles from acceptance to array commit; must be >= 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  ADDR_WIDTH  word address. Block index = `mem_addr[ADDR_WIDTH-1:$clog2(BLOCK_SIZE)]`; offset bits are ignored.
- `mem_data_out`  in  BLOCK_SIZE x DATA_WIDTH  write block from L2.
- `mem_read`  in  1  read request, level-held by L2 until `mem_ready`.
- `mem_write`  in  1  write request; every high cycle is one write.
- `mem_data_block`  out  BLOCK_SIZE x DATA_WIDTH  read data; holds its value until the next read completes.
- `mem_ready`  out  1  one-cycle pulse when a read completes.
- `mem_hit`  out  1  valid only with `mem_ready`; 1 means the block was written since reset.
- `mem_wr_ack`  out  1  one-cycle pulse when a write commits.
- `mem_busy`  out  1  high while an operation is in progress or pending.
- `mem_overrun`  out  1  sticky error flag; set when a request is dropped.

## Operation
- **Read acceptance:** a read is accepted on the rising edge of `mem_read` (high this cycle, low the previous cycle). A level held high never triggers a second read.
- **Write acceptance:** every cycle with `mem_write` high is one write. Address and data are captured at that edge.
- **States:**
  - IDLE → RD_BUSY on a read; IDLE → WR_BUSY on a write.
  - Latency counter is loaded with latency-1 and counts down; the operation completes when the counter reaches 0.
  - On completion: move to the next pending operation (write first), else return to IDLE.
- **Pending slots:** one pending-write slot and one pending-read slot.
  - A request arriving while busy goes into its slot.
  - If a read and a write arrive in the same cycle while IDLE, the write starts and the read goes to pending.
  - A pending write is always serviced before a pending read, so a read of the same block returns the newly written data.
- **Overrun:** a request arriving while its slot is already full is dropped and sets `mem_overrun`. Only reset clears `mem_overrun`.
- **Storage:** `valid[NUM_BLOCKS]` tracks which blocks have been written. A write sets `valid`. A read of an invalid block returns all zeros with `mem_hit`=0.
- **Reset values:** all outputs 0, state IDLE, counter 0, pending slots empty, `valid` cleared.
  - Reset asserted mid-operation aborts it; an uncommitted write is lost.
  - Array data words are not reset.

## Timing
- **Read:** accepted at edge E0. `mem_ready`, `mem_hit` and `mem_data_block` are registered high/valid at edge E0+READ_LATENCY, for exactly one cycle.
- **Write:** accepted at E0. The array and `valid` update at edge E0+WRITE_LATENCY; `mem_wr_ack` is high for the cycle that follows that edge.
- **Back-to-back:** a pending operation starts at the completion edge of the previous one. For example, pending read latency counts from that edge, so there are no idle cycles between operations.
- **`mem_busy`:** high from the cycle after acceptance until the cycle after the last completion edge.
- **L2 compatibility:** L2 holds `mem_read` high for one cycle after `mem_ready`. This extra cycle must not start a new read (covered by rising-edge acceptance).

## Configuration
- `MAIN_MEM_INIT_EN`
  - Defined: reset loads every word with its own word address (zero-extended to DATA_WIDTH) and sets every `valid` bit, so every read reports `mem_hit`=1.
  - Undefined: behaviour as described above (`valid` cleared, unwritten blocks read as zero).

## Test plan
- **Cold read:** no macro, read addr 0x040 → after 4 cycles `mem_ready`=1, `mem_hit`=0, block all zeros.
- **Write then read:** write addr 0x040 with word i = 0xA000+i; read asserted the next cycle → read pending, `mem_wr_ack` at +2. `mem_ready` at +6 from the write, with `mem_hit`=1 and word 5 = 0xA005.
- **Held request:** hold `mem_read` high for 6 cycles → exactly one `mem_ready` pulse.
- **Overrun:** three `mem_write` cycles in a row → first executes, second is pending, third is dropped. `mem_overrun`=1; only two `mem_wr_ack` pulses.
- **Reset mid-write:** `rst_n` low 1 cycle after a write to 0x080 → no `mem_wr_ack`; a later read of 0x080 returns `mem_hit`=0. All outputs read 0 during reset.
- **Init pattern:** with `MAIN_MEM_INIT_EN` defined, read 0x7E0 → `mem_hit`=1, word 3 = 0x000007E3.

Source files
------------

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency block-granular backing store behind the L2.
// Optional build macro MAIN_MEM_INIT_EN: reset preloads every word with its own
// word address and marks every block valid.
module main_memory_responder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                  mem_ready,
  output logic                                  mem_hit,
  output logic                                  mem_wr_ack,
  output logic                                  mem_busy,
  output logic                                  mem_overrun
);

  localparam int unsigned OFF_W      = $clog2(BLOCK_SIZE);
  localparam int unsigned BLK_W      = ADDR_WIDTH - OFF_W;
  localparam int unsigned NUM_BLOCKS = 2 ** BLK_W;
  localparam int unsigned MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLK_W-1:0]     op_blk_q, op_blk_d;
  block_t               op_data_q, op_data_d;
  logic                 pw_valid_q, pw_valid_d;
  logic [BLK_W-1:0]     pw_blk_q, pw_blk_d;
  block_t               pw_data_q, pw_data_d;
  logic                 pr_valid_q, pr_valid_d;
  logic [BLK_W-1:0]     pr_blk_q, pr_blk_d;
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic                 rd_prev_q, rd_prev_d;
  block_t               data_block_q, data_block_d;
  logic                 ready_q, ready_d;
  logic                 hit_q, hit_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  block_t               mem_array_q [NUM_BLOCKS];

  logic                 rd_req_c;
  logic                 done_c;
  logic                 mem_wr_en_c;
  logic                 take_new_wr_c;
  logic                 take_new_rd_c;
  logic [BLK_W-1:0]     req_blk_c;
  logic                 unused_addr_c;

  assign rd_req_c      = mem_read & ~rd_prev_q;
  assign req_blk_c     = mem_addr[ADDR_WIDTH-1:OFF_W];
  assign unused_addr_c = ^mem_addr[OFF_W-1:0];

  // Completion, next-operation selection (pending write first) and slot filling.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_blk_d      = op_blk_q;
    op_data_d     = op_data_q;
    pw_valid_d    = pw_valid_q;
    pw_blk_d      = pw_blk_q;
    pw_data_d     = pw_data_q;
    pr_valid_d    = pr_valid_q;
    pr_blk_d      = pr_blk_q;
    valid_d       = valid_q;
    rd_prev_d     = mem_read;
    data_block_d  = data_block_q;
    ready_d       = 1'b0;
    hit_d         = 1'b0;
    wr_ack_d      = 1'b0;
    overrun_d     = overrun_q;
    mem_wr_en_c   = 1'b0;
    take_new_wr_c = 1'b0;
    take_new_rd_c = 1'b0;
    done_c        = (state_q != IDLE) && (cnt_q == '0);

    if ((state_q != IDLE) && !done_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (done_c) begin
      if (state_q == RD_BUSY) begin
        ready_d      = 1'b1;
        hit_d        = valid_q[op_blk_q];
        data_block_d = valid_q[op_blk_q] ? mem_array_q[op_blk_q] : '0;
      end else begin
        mem_wr_en_c        = 1'b1;
        valid_d[op_blk_q]  = 1'b1;
        wr_ack_d           = 1'b1;
      end
    end

    if ((state_q == IDLE) || done_c) begin
      state_d = IDLE;
      if (pw_valid_q) begin
        state_d    = WR_BUSY;
        cnt_d      = CNT_W'(WRITE_LATENCY - 1);
        op_blk_d   = pw_blk_q;
        op_data_d  = pw_data_q;
        pw_valid_d = 1'b0;
      end else if (mem_write) begin
        state_d       = WR_BUSY;
        cnt_d         = CNT_W'(WRITE_LATENCY - 1);
        op_blk_d      = req_blk_c;
        op_data_d     = mem_data_out;
        take_new_wr_c = 1'b1;
      end else if (pr_valid_q) begin
        state_d    = RD_BUSY;
        cnt_d      = CNT_W'(READ_LATENCY - 1);
        op_blk_d   = pr_blk_q;
        pr_valid_d = 1'b0;
      end else if (rd_req_c) begin
        state_d       = RD_BUSY;
        cnt_d         = CNT_W'(READ_LATENCY - 1);
        op_blk_d      = req_blk_c;
        take_new_rd_c = 1'b1;
      end
    end

    // A request not started this edge goes to its slot, or is dropped if the slot was full.
    if (mem_write && !take_new_wr_c) begin
      if (pw_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        pw_valid_d = 1'b1;
        pw_blk_d   = req_blk_c;
        pw_data_d  = mem_data_out;
      end
    end
    if (rd_req_c && !take_new_rd_c) begin
      if (pr_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        pr_valid_d = 1'b1;
        pr_blk_d   = req_blk_c;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_blk_q     <= '0;
      op_data_q    <= '0;
      pw_valid_q   <= 1'b0;
      pw_blk_q     <= '0;
      pw_data_q    <= '0;
      pr_valid_q   <= 1'b0;
      pr_blk_q     <= '0;
`ifdef MAIN_MEM_INIT_EN
      valid_q      <= '1;
`else
      valid_q      <= '0;
`endif
      rd_prev_q    <= 1'b0;
      data_block_q <= '0;
      ready_q      <= 1'b0;
      hit_q        <= 1'b0;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_blk_q     <= op_blk_d;
      op_data_q    <= op_data_d;
      pw_valid_q   <= pw_valid_d;
      pw_blk_q     <= pw_blk_d;
      pw_data_q    <= pw_data_d;
      pr_valid_q   <= pr_valid_d;
      pr_blk_q     <= pr_blk_d;
      valid_q      <= valid_d;
      rd_prev_q    <= rd_prev_d;
      data_block_q <= data_block_d;
      ready_q      <= ready_d;
      hit_q        <= hit_d;
      wr_ack_q     <= wr_ack_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef MAIN_MEM_INIT_EN
  // Storage array; reset preloads each word with its own word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        for (int unsigned w = 0; w < BLOCK_SIZE; w++) begin
          mem_array_q[b][w] <= DATA_WIDTH'(b * BLOCK_SIZE + w);
        end
      end
    end else if (mem_wr_en_c) begin
      mem_array_q[op_blk_q] <= op_data_q;
    end
  end
`else
  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en_c) begin
      mem_array_q[op_blk_q] <= op_data_q;
    end
  end
`endif

  assign mem_data_block = data_block_q;
  assign mem_ready      = ready_q;
  assign mem_hit        = hit_q;
  assign mem_wr_ack     = wr_ack_q;
  assign mem_busy       = busy_q;
  assign mem_overrun    = overrun_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with a scoreboard of expected
// read completions and write acknowledgements, each tagged with its cycle.
module tb_main_memory_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 11;
  localparam int unsigned BS = 32;
  localparam int unsigned RL = 4;
  localparam int unsigned WL = 2;

  typedef logic [BS-1:0][DW-1:0] block_t;
  typedef struct {
    int unsigned cyc;
    logic        hit;
    block_t      data;
  } rd_exp_t;

`ifdef MAIN_MEM_INIT_EN
  localparam logic COLD_HIT = 1'b1;
`else
  localparam logic COLD_HIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  block_t        mem_data_out;
  logic          mem_read;
  logic          mem_write;
  block_t        mem_data_block;
  logic          mem_ready;
  logic          mem_hit;
  logic          mem_wr_ack;
  logic          mem_busy;
  logic          mem_overrun;

  main_memory_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data_block (mem_data_block),
    .mem_ready      (mem_ready),
    .mem_hit        (mem_hit),
    .mem_wr_ack     (mem_wr_ack),
    .mem_busy       (mem_busy),
    .mem_overrun    (mem_overrun)
  );

  always #5 clk = ~clk;

  rd_exp_t     rdq[$];
  int unsigned ackq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ready_cnt = 0;
  int          ack_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input block_t obs, input block_t exp);
    int bad = 0;
    for (int w = BS - 1; w >= 0; w--) begin
      if (obs[w] !== exp[w]) bad = w;
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s word %0d observed=%0h expected=%0h", tag, bad, obs[bad], exp[bad]);
    end
  endtask

  // Expected contents of a block that was never written since reset.
  function automatic block_t cold_data(input logic [AW-1:0] a);
    block_t b = '0;
`ifdef MAIN_MEM_INIT_EN
    for (int w = 0; w < BS; w++) b[w] = DW'({a[AW-1:5], 5'(w)});
`endif
    return b;
  endfunction

  function automatic block_t pattern(input int unsigned base);
    block_t b;
    for (int w = 0; w < BS; w++) b[w] = DW'(base + w);
    return b;
  endfunction

  // One clock; outputs sampled 1 time unit after the rising edge and scored.
  task automatic step();
    rd_exp_t e;
    int unsigned a;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_ready) begin
      ready_cnt++;
      chk("ready_has_request", 64'(rdq.size() != 0), 64'(1));
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("ready_hit", 64'(mem_hit), 64'(e.hit));
        chk_blk("ready_data", mem_data_block, e.data);
      end
    end
    if (mem_wr_ack) begin
      ack_cnt++;
      chk("ack_has_write", 64'(ackq.size() != 0), 64'(1));
      if (ackq.size() != 0) begin
        a = ackq.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(a));
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((rdq.size() != 0 || ackq.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(rdq.size() + ackq.size()), 64'(0));
    rdq.delete();
    ackq.delete();
  endtask

  // Read as the L2 does it: level held until mem_ready plus one extra cycle.
  task automatic do_read(input logic [AW-1:0] a, input logic hit, input block_t d);
    mem_addr = a;
    mem_read = 1'b1;
    step();
    rdq.push_back('{cyc + RL, hit, d});
    chk("busy_after_accept", 64'(mem_busy), 64'(1));
    drain(40);
    step();
    mem_read = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(mem_ready), 64'(0));
    chk({tag, "_hit"}, 64'(mem_hit), 64'(0));
    chk({tag, "_ack"}, 64'(mem_wr_ack), 64'(0));
    chk({tag, "_busy"}, 64'(mem_busy), 64'(0));
    chk({tag, "_overrun"}, 64'(mem_overrun), 64'(0));
    chk_blk({tag, "_data"}, mem_data_block, '0);
  endtask

  initial begin
    int unsigned e0;
    int          base;
    block_t      wa, wb, wc, tmp;

    rst_n        = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Cold read of a never-written block.
    do_read(11'h040, COLD_HIT, cold_data(11'h040));
    chk("cold_idle_after", 64'(mem_busy), 64'(0));
    chk_blk("cold_data_holds", mem_data_block, cold_data(11'h040));

    // Held request: six high cycles give exactly one completion.
    base = ready_cnt;
    mem_addr = 11'h060;
    mem_read = 1'b1;
    step();
    rdq.push_back('{cyc + RL, COLD_HIT, cold_data(11'h060)});
    repeat (5) step();
    mem_read = 1'b0;
    step();
    drain(10);
    chk("held_one_pulse", 64'(ready_cnt - base), 64'(1));

    // Write then read next cycle: read waits in the pending slot.
    wa = pattern(32'hA000);
    mem_addr     = 11'h040;
    mem_data_out = wa;
    mem_write    = 1'b1;
    step();
    e0 = cyc;
    ackq.push_back(e0 + WL);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    step();
    rdq.push_back('{e0 + 6, 1'b1, wa});
    drain(40);
    step();
    mem_read = 1'b0;
    step();
    chk("wr_rd_word5", 64'(mem_data_block[5]), 64'(32'hA005));
    chk("no_overrun_yet", 64'(mem_overrun), 64'(0));

    // Three consecutive writes: first runs, second pends, third is dropped.
    base = ack_cnt;
    wa = pattern(32'h1100);
    wb = pattern(32'h2200);
    wc = pattern(32'h3300);
    mem_write    = 1'b1;
    mem_addr     = 11'h100;
    mem_data_out = wa;
    step();
    e0 = cyc;
    ackq.push_back(e0 + 2);
    mem_addr     = 11'h120;
    mem_data_out = wb;
    step();
    ackq.push_back(e0 + 4);
    mem_addr     = 11'h140;
    mem_data_out = wc;
    step();
    mem_write = 1'b0;
    drain(20);
    repeat (3) step();
    chk("overrun_set", 64'(mem_overrun), 64'(1));
    chk("overrun_two_acks", 64'(ack_cnt - base), 64'(2));
    do_read(11'h100, 1'b1, wa);
    do_read(11'h120, 1'b1, wb);
    do_read(11'h140, COLD_HIT, cold_data(11'h140));
    chk("overrun_sticky", 64'(mem_overrun), 64'(1));

    // Read and write in the same idle cycle: write first, read sees new data.
    wa = pattern(32'h5A00);
    mem_addr     = 11'h180;
    mem_data_out = wa;
    mem_write    = 1'b1;
    mem_read     = 1'b1;
    step();
    e0 = cyc;
    ackq.push_back(e0 + WL);
    rdq.push_back('{e0 + WL + RL, 1'b1, wa});
    mem_write = 1'b0;
    drain(40);
    step();
    mem_read = 1'b0;
    step();

    // Reset one cycle after a write: the write is lost.
    mem_addr     = 11'h080;
    mem_data_out = pattern(32'hBEE0);
    mem_write    = 1'b1;
    step();
    mem_write = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    do_read(11'h080, COLD_HIT, cold_data(11'h080));

    // Top block: address pattern when preloaded, zeros otherwise.
    do_read(11'h7E0, COLD_HIT, cold_data(11'h7E0));
    tmp = cold_data(11'h7E0);
    chk("top_word3", 64'(mem_data_block[3]), 64'(tmp[3]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
